// File: rtl/emblem_layer_mixer_if.sv
// Pixel-stream bundle between the VGA timing/layer sources and the
// emblem layer mixer. The master drives timing and layer pixels; the
// slave (the mixer) returns the composited, registered VGA signals.
interface emblem_layer_mixer_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       next_frame;
  logic       enable;
  logic [5:0] bg_rgb;
  logic       emblem_draw;
  logic [5:0] emblem_rgb;
  logic       text_draw;
  logic [5:0] text_rgb;
  logic [5:0] rgb_out;
  logic       hsync_out;
  logic       vsync_out;
  logic [2:0] fade_level;
  logic [1:0] fade_state;

  modport master (
    output x, y, active, hsync, vsync, next_frame, enable,
           bg_rgb, emblem_draw, emblem_rgb, text_draw, text_rgb,
    input  rgb_out, hsync_out, vsync_out, fade_level, fade_state
  );

  modport slave (
    input  x, y, active, hsync, vsync, next_frame, enable,
           bg_rgb, emblem_draw, emblem_rgb, text_draw, text_rgb,
    output rgb_out, hsync_out, vsync_out, fade_level, fade_state
  );
endinterface

// File: rtl/emblem_layer_mixer.sv
// Final VGA compositor: background, dithered fading emblem, text on top.
// The fade FSM advances only on frame pulses; the pixel path has exactly
// one cycle of latency, with hsync/vsync delayed to match.
module emblem_layer_mixer #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_FRAMES     = 120,
  parameter int HIDE_FRAMES     = 60,
  parameter int CNT_W           = 8
) (
  input logic                clk,
  input logic                rst_n,
  emblem_layer_mixer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HIDDEN   = 2'b00,
    ST_FADE_IN  = 2'b01,
    ST_SHOWN    = 2'b10,
    ST_FADE_OUT = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] HIDE_LAST = CNT_W'(HIDE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_r, state_s;
  logic [2:0]       level_r, level_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       thresh_s;
  logic             emblem_vis_s;
  logic [5:0]       rgb_s;

  assign bus.fade_level = level_r;
  assign bus.fade_state = state_r;

  // Fade FSM state, level and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_HIDDEN;
      level_r <= 3'd0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      level_r <= level_s;
      cnt_r   <= cnt_s;
    end
  end

  // Fade FSM next state: only frame pulses move it; otherwise everything holds.
  always_comb begin
    state_s = state_r;
    level_s = level_r;
    cnt_s   = cnt_r;
    if (bus.next_frame) begin
      case (state_r)
        ST_HIDDEN: begin
          if (!bus.enable) begin
            cnt_s = {CNT_W{1'b0}};
          end else if (cnt_r == HIDE_LAST) begin
            state_s = ST_FADE_IN;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_FADE_IN: begin
          if (!bus.enable) begin
            state_s = ST_FADE_OUT;
            cnt_s   = {CNT_W{1'b0}};
          end else if (cnt_r == STEP_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            if (level_r >= 3'd3) begin
              level_s = 3'd4;
              state_s = ST_SHOWN;
            end else begin
              level_s = level_r + 3'd1;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_SHOWN: begin
          if (!bus.enable || (cnt_r == HOLD_LAST)) begin
            state_s = ST_FADE_OUT;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_FADE_OUT: begin
          // A level already at 0 (aborted fade-in) drops straight to hidden.
          if (cnt_r == STEP_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            if (level_r <= 3'd1) begin
              level_s = 3'd0;
              state_s = ST_HIDDEN;
            end else begin
              level_s = level_r - 3'd1;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = ST_HIDDEN;
          level_s = 3'd0;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
      level_s = level_r;
      cnt_s   = cnt_r;
    end
  end

  // Layer priority with 2x2 ordered dither against the pre-update level.
  always_comb begin
    thresh_s     = {bus.x[0] ^ bus.y[0], bus.y[0]};
    emblem_vis_s = bus.emblem_draw && ({1'b0, thresh_s} < level_r);
    rgb_s        = 6'd0;
    if (!bus.active) begin
      rgb_s = 6'd0;
    end else if (bus.text_draw) begin
      rgb_s = bus.text_rgb;
    end else if (emblem_vis_s) begin
      rgb_s = bus.emblem_rgb;
    end else begin
      rgb_s = bus.bg_rgb;
    end
  end

  // Output pixel and syncs registered together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rgb_out   <= 6'd0;
      bus.hsync_out <= 1'b1;
      bus.vsync_out <= 1'b1;
    end else begin
      bus.rgb_out   <= rgb_s;
      bus.hsync_out <= bus.hsync;
      bus.vsync_out <= bus.vsync;
    end
  end

endmodule

// File: tb/tb_emblem_layer_mixer.sv
// Directed bench for emblem_layer_mixer: table-driven pixel vectors plus
// hand-written sequences for reset, the fade timeline and enable abort.
module tb_emblem_layer_mixer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  emblem_layer_mixer_if bus();

  emblem_layer_mixer #(
    .FRAMES_PER_STEP(2),
    .HOLD_FRAMES    (3),
    .HIDE_FRAMES    (2),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [2:0] lvl;
    logic       x0;
    logic       y0;
    logic       act;
    logic       td;
    logic       ed;
    logic [5:0] trgb;
    logic [5:0] ergb;
    logic [5:0] bg;
    logic [5:0] exp_rgb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.next_frame = 1'b1;
    tick();
    bus.next_frame = 1'b0;
  endtask

  task automatic add_vec(input string name, input logic [2:0] lvl, input logic x0,
                         input logic y0, input logic act, input logic td, input logic ed,
                         input logic [5:0] trgb, input logic [5:0] ergb,
                         input logic [5:0] bg, input logic [5:0] exp_rgb);
    vec_t v;
    v.name = name; v.lvl = lvl; v.x0 = x0; v.y0 = y0; v.act = act; v.td = td;
    v.ed = ed; v.trgb = trgb; v.ergb = ergb; v.bg = bg; v.exp_rgb = exp_rgb;
    vecs.push_back(v);
  endtask

  // Apply every table vector tagged with the current level and check rgb_out.
  task automatic apply_vecs(input logic [2:0] lvl);
    foreach (vecs[i]) begin
      if (vecs[i].lvl == lvl) begin
        bus.x           = 10'd100 + {9'd0, vecs[i].x0};
        bus.y           = 10'd200 + {9'd0, vecs[i].y0};
        bus.active      = vecs[i].act;
        bus.text_draw   = vecs[i].td;
        bus.emblem_draw = vecs[i].ed;
        bus.text_rgb    = vecs[i].trgb;
        bus.emblem_rgb  = vecs[i].ergb;
        bus.bg_rgb      = vecs[i].bg;
        tick();
        chk(vecs[i].name, bus.rgb_out, vecs[i].exp_rgb);
      end
    end
  endtask

  int exp_st[1:23] = '{0,1,1,1,1,1,1,1,1,2,2,2,3,3,3,3,3,3,3,3,0,0,1};
  int exp_lv[1:23] = '{0,0,0,1,1,2,2,3,3,4,4,4,4,4,3,3,2,2,1,1,0,0,0};

  initial begin
    int hold_st;
    int hold_lv;
    checks   = 0;
    failures = 0;

    add_vec("l0_emblem_hidden", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h33);
    add_vec("l1_tile00",        3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h2A);
    add_vec("l1_tile11",        3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h33);
    add_vec("l2_tile00",        3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h2A);
    add_vec("l2_tile10",        3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h33);
    add_vec("l2_tile01",        3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h33);
    add_vec("l2_tile11",        3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h2A);
    add_vec("l4_text_wins",     3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h15);
    add_vec("l4_emblem",        3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h2A);
    add_vec("l4_inactive",      3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h00);
    add_vec("l4_bg_no_draw",    3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h15, 6'h2A, 6'h33, 6'h33);
    add_vec("l4_tile01",        3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h2A);
    add_vec("l4_tile11",        3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h33, 6'h2A);

    bus.x = 10'd0; bus.y = 10'd0; bus.active = 1'b0;
    bus.hsync = 1'b1; bus.vsync = 1'b1; bus.next_frame = 1'b0; bus.enable = 1'b1;
    bus.bg_rgb = 6'd0; bus.emblem_draw = 1'b0; bus.emblem_rgb = 6'd0;
    bus.text_draw = 1'b0; bus.text_rgb = 6'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("por_rgb", bus.rgb_out, 0);
    chk("por_hsync", bus.hsync_out, 1);
    chk("por_vsync", bus.vsync_out, 1);
    chk("por_level", bus.fade_level, 0);
    chk("por_state", bus.fade_state, 0);
    #5 rst_n = 1'b1;
    tick();

    // Drive a non-reset picture and advance the FSM into FADE_IN.
    bus.active = 1'b1; bus.bg_rgb = 6'b101010; bus.hsync = 1'b0; bus.vsync = 1'b0;
    pulse(); pulse(); pulse();
    chk("pre_rst_state", bus.fade_state, 1);
    chk("pre_rst_rgb", bus.rgb_out, 6'b101010);
    chk("pre_rst_hsync", bus.hsync_out, 0);

    // Mid-line asynchronous reset: outputs must drop before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", bus.rgb_out, 0);
    chk("mid_rst_hsync", bus.hsync_out, 1);
    chk("mid_rst_vsync", bus.vsync_out, 1);
    chk("mid_rst_level", bus.fade_level, 0);
    chk("mid_rst_state", bus.fade_state, 0);
    bus.hsync = 1'b1; bus.vsync = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    chk("rel_first_rgb", bus.rgb_out, 6'b101010);
    bus.hsync = 1'b0;
    #3;
    chk("hsync_not_yet", bus.hsync_out, 1);
    tick();
    chk("hsync_delayed", bus.hsync_out, 0);
    bus.hsync = 1'b1;
    tick();
    chk("hsync_back", bus.hsync_out, 1);

    apply_vecs(3'd0);

    // Full fade timeline with enable high, pixel tables at levels 1, 2, 4.
    for (int p = 1; p <= 23; p++) begin
      if (p == 10) begin
        bus.x = 10'd100; bus.y = 10'd201; bus.active = 1'b1; bus.text_draw = 1'b0;
        bus.emblem_draw = 1'b1; bus.emblem_rgb = 6'h2A; bus.bg_rgb = 6'h33;
      end
      pulse();
      chk($sformatf("tl_state_p%0d", p), bus.fade_state, exp_st[p]);
      chk($sformatf("tl_level_p%0d", p), bus.fade_level, exp_lv[p]);
      if (p == 10) chk("edge_uses_old_level", bus.rgb_out, 6'h33);
      if (p == 4)  apply_vecs(3'd1);
      if (p == 6)  apply_vecs(3'd2);
      if (p == 10) apply_vecs(3'd4);
      tick(); tick();
    end

    // Climb to level 2 in FADE_IN, then drop enable.
    pulse(); pulse(); pulse(); pulse();
    chk("ab_pre_state", bus.fade_state, 1);
    chk("ab_pre_level", bus.fade_level, 2);
    bus.enable = 1'b0;
    pulse();
    chk("ab_fo_state", bus.fade_state, 3);
    chk("ab_fo_level", bus.fade_level, 2);
    pulse();
    chk("ab_p1_level", bus.fade_level, 2);
    pulse();
    chk("ab_p2_level", bus.fade_level, 1);
    pulse();
    chk("ab_p3_state", bus.fade_state, 3);
    pulse();
    chk("ab_hidden_state", bus.fade_state, 0);
    chk("ab_hidden_level", bus.fade_level, 0);
    pulse(); pulse(); pulse();
    chk("ab_stay_hidden", bus.fade_state, 0);
    // A cleared counter needs exactly two enabled pulses to leave HIDDEN.
    bus.enable = 1'b1;
    pulse();
    chk("ab_cnt_cleared", bus.fade_state, 0);
    pulse();
    chk("ab_refade_in", bus.fade_state, 1);
    pulse(); pulse();
    chk("hold_pre_level", bus.fade_level, 1);

    // Long stretch without frame pulses: FSM must not move.
    hold_st = bus.fade_state;
    hold_lv = bus.fade_level;
    for (int c = 0; c < 1000; c++) begin
      bus.enable = $urandom_range(0, 1) == 1;
      tick();
      chk("hold_state", bus.fade_state, hold_st);
      chk("hold_level", bus.fade_level, hold_lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
